// File: rtl/sl3_fec_word_lock.sv
// sl3_fec_word_lock: sync-header word alignment hunter with 10GBASE-R style block lock
module sl3_fec_word_lock #(
    parameter int WIDTH     = 40,
    parameter int LOCK_GOOD = 64,
    parameter int WIN       = 1024,
    parameter int BAD_LIM   = 16,
    parameter int SLIP_WAIT = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             slip,
    output logic             locked,
    output logic [7:0]       lock_losses
);
    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int NW = $clog2(WIN + 1);
    localparam int BW = $clog2(BAD_LIM + 1);
    localparam int TW = $clog2(SLIP_WAIT + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_GOOD);
    localparam logic [NW-1:0] WIN_MAX  = NW'(WIN);
    localparam logic [BW-1:0] BAD_MAX  = BW'(BAD_LIM);
    localparam logic [TW-1:0] WAIT_MAX = TW'(SLIP_WAIT);

    typedef enum logic [1:0] {S_HUNT, S_WAIT, S_LOCKED} state_t;

    state_t        state, state_n;
    logic [GW-1:0] good_cnt, good_n, good_inc;
    logic [NW-1:0] win_cnt, win_n, win_inc;
    logic [BW-1:0] bad_cnt, bad_n, bad_sum;
    logic [TW-1:0] wait_cnt, wait_n, wait_inc;
    logic          slip_n;
    logic [7:0]    losses_n;
    logic          good;

    assign good     = din[1] ^ din[0];
    assign good_inc = good_cnt + 1'b1;
    assign win_inc  = win_cnt + 1'b1;
    assign bad_sum  = bad_cnt + BW'(!good);
    assign wait_inc = wait_cnt + 1'b1;
    assign locked   = (state == S_LOCKED);

    // Register the data path through with one cycle of latency, independent of lock
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout       <= din;
            dout_valid <= din_valid;
        end
    end

    // Lock FSM state, counters, slip pulse and loss counter
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= S_HUNT;
            good_cnt    <= '0;
            win_cnt     <= '0;
            bad_cnt     <= '0;
            wait_cnt    <= '0;
            slip        <= 1'b0;
            lock_losses <= '0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_n;
            win_cnt     <= win_n;
            bad_cnt     <= bad_n;
            wait_cnt    <= wait_n;
            slip        <= slip_n;
            lock_losses <= losses_n;
        end
    end

    // Next-state logic; invalid cycles hold everything and never slip
    always_comb begin
        state_n  = state;
        good_n   = good_cnt;
        win_n    = win_cnt;
        bad_n    = bad_cnt;
        wait_n   = wait_cnt;
        slip_n   = 1'b0;
        losses_n = lock_losses;
        if (din_valid) begin
            case (state)
                S_HUNT: begin
                    if (good) begin
                        good_n = good_inc;
                        if (good_inc == GOOD_MAX) begin
                            state_n = S_LOCKED;
                            good_n  = '0;
                            win_n   = '0;
                            bad_n   = '0;
                        end
                    end else begin
                        good_n  = '0;
                        wait_n  = '0;
                        slip_n  = 1'b1;
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_n = wait_inc;
                    if (wait_inc == WAIT_MAX) begin
                        state_n = S_HUNT;
                        good_n  = '0;
                        wait_n  = '0;
                    end
                end
                S_LOCKED: begin
                    win_n = win_inc;
                    bad_n = bad_sum;
                    if (bad_sum == BAD_MAX) begin
                        state_n  = S_WAIT;
                        slip_n   = 1'b1;
                        losses_n = (lock_losses == 8'hff) ? lock_losses : lock_losses + 8'd1;
                        good_n   = '0;
                        wait_n   = '0;
                        win_n    = '0;
                        bad_n    = '0;
                    end else if (win_inc == WIN_MAX) begin
                        win_n = '0;
                        bad_n = '0;
                    end
                end
                default: state_n = S_HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_sl3_fec_word_lock.sv
// tb_sl3_fec_word_lock: directed self-checking bench for the word-lock stage
module tb_sl3_fec_word_lock;
    localparam int WIDTH = 40;

    logic             clk;
    logic             arst_n;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             slip;
    logic             locked;
    logic [7:0]       lock_losses;

    int               checks = 0;
    int               errors = 0;
    int               k = 0;
    logic [WIDTH-1:0] prev_din;
    logic             prev_v;

    sl3_fec_word_lock #(
        .WIDTH(WIDTH), .LOCK_GOOD(4), .WIN(16), .BAD_LIM(3), .SLIP_WAIT(2)
    ) dut (
        .clk(clk), .arst_n(arst_n), .din_valid(din_valid), .din(din),
        .dout(dout), .dout_valid(dout_valid), .slip(slip), .locked(locked),
        .lock_losses(lock_losses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word at the negedge, check the previous word on dout, then check lock/slip after the edge
    task automatic cyc(input logic v, input logic [1:0] h, input logic el, input logic es);
        @(negedge clk);
        din_valid = v;
        din = {38'(k * 7 + 3), h};
        k++;
        #1;
        chk("dout", dout, prev_din);
        chk("dout_valid", dout_valid, prev_v);
        prev_din = din;
        prev_v = v;
        @(posedge clk);
        #1;
        chk("locked", locked, el);
        chk("slip", slip, es);
    endtask

    initial begin
        arst_n = 1'b0;
        din_valid = 1'b0;
        din = '0;
        prev_din = '0;
        prev_v = 1'b0;
        #12;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_slip", slip, 0);
        chk("rst_locked", locked, 0);
        chk("rst_losses", lock_losses, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // initial lock after 4 good headers
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b01, 1, 0);

        // two bad headers per 16-word window keeps lock
        for (int w = 0; w < 3; w++)
            for (int i = 1; i <= 16; i++)
                cyc(1, (i == 3 || i == 10) ? 2'b11 : 2'b01, 1, 0);
        chk("losses_win", lock_losses, 0);

        // third bad header inside a window drops lock
        cyc(1, 2'b11, 1, 0);
        cyc(1, 2'b01, 1, 0);
        cyc(1, 2'b00, 1, 0);
        cyc(1, 2'b01, 1, 0);
        cyc(1, 2'b11, 0, 1);
        chk("losses_one", lock_losses, 1);

        // wait window after the loss, then hunt: good, good, bad slips
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b00, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b11, 0, 1);
        cyc(1, 2'b11, 0, 0);
        cyc(1, 2'b00, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 1, 0);
        chk("losses_hold", lock_losses, 1);

        // mid-window asynchronous reset
        cyc(1, 2'b01, 1, 0);
        cyc(1, 2'b11, 1, 0);
        cyc(1, 2'b01, 1, 0);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_slip", slip, 0);
        chk("arst_dout", dout, 0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_losses", lock_losses, 0);
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        prev_din = '0;
        prev_v = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;

        // relock with din_valid toggling; invalid bad headers are ignored
        cyc(1, 2'b01, 0, 0);
        cyc(0, 2'b11, 0, 0);
        cyc(1, 2'b10, 0, 0);
        cyc(0, 2'b01, 0, 0);
        cyc(1, 2'b01, 0, 0);
        cyc(0, 2'b00, 0, 0);
        cyc(1, 2'b10, 1, 0);
        chk("relock_losses", lock_losses, 0);
        cyc(0, 2'b01, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
